// File: rtl/image_seq_pkg.sv
// Shared types and constants for the image sequencer.
// Holds the copy FSM state encoding and the image select wrap helper.
package image_seq_pkg;

  localparam int PIXEL_W = 3;
  localparam int ADDR_W  = 17;
  localparam int SEL_W   = 2;

  typedef enum logic [1:0] {
    IDLE,
    COPY,
    DRAIN,
    DONE
  } seq_state_e;

  function automatic logic [SEL_W-1:0] next_sel(
    input logic [SEL_W-1:0] sel,
    input int               n
  );
    return (int'(sel) >= n - 1) ? '0 : sel + 1'b1;
  endfunction

endpackage

// File: rtl/image_sequencer_button_debounce.sv
// Button synchronizer and debouncer for an active-low push button.
// Emits a one-cycle press pulse per debounced press.
module button_debounce #(
  parameter int CYCLES = 500000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_ni,
  output logic press_o
);

  localparam int CW = $clog2(CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CYCLES - 1);

  logic [1:0]    sync_q;
  logic          stable_q;
  logic [CW-1:0] cnt_q;
  logic          press_q;

  // stable_q is the debounced level; it only flips after a full
  // run of CYCLES samples disagreeing with it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q   <= 2'b11;
      stable_q <= 1'b1;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_ni};
      press_q <= 1'b0;
      if (sync_q[1] == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        stable_q <= sync_q[1];
        cnt_q    <= '0;
        press_q  <= ~sync_q[1];
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/image_sequencer.sv
// Copies a selected image ROM into the frame buffer on each button press.
// IMAGE_SEQ_AUTO_EN adds a timer that advances the image while idle.
module image_sequencer
  import image_seq_pkg::*;
#(
  parameter int NUM_IMAGES      = 3,
  parameter int PIXELS          = 76800,
  parameter int DEBOUNCE_CYCLES = 500000
`ifdef IMAGE_SEQ_AUTO_EN
  ,
  parameter int AUTO_PERIOD_CYCLES = 150000000
`endif
) (
  input  logic               i_clk,
  input  logic               i_resetL,
  input  logic               i_nextL,
  output logic [SEL_W-1:0]   o_rom_sel,
  output logic [ADDR_W-1:0]  o_rom_addr,
  input  logic [PIXEL_W-1:0] i_rom_data,
  output logic [ADDR_W-1:0]  o_fb_addr,
  output logic [PIXEL_W-1:0] o_fb_data,
  output logic               o_fb_we,
  output logic               o_flush,
  output logic               o_busy
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(PIXELS - 1);

  seq_state_e        state_q;
  logic [SEL_W-1:0]  sel_q;
  logic [ADDR_W-1:0] rom_addr_q;
  logic [ADDR_W-1:0] fb_addr_q;
  logic              fb_we_q;
  logic              flush_q;
  logic              busy_q;
  logic              pend_q;
  logic              boot_q;

  logic press;
  logic auto_hit;
  logic go_d;
  logic start_d;

  button_debounce #(
    .CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk_i  (i_clk),
    .rst_ni (i_resetL),
    .btn_ni (i_nextL),
    .press_o(press)
  );

  assign go_d    = press | pend_q | auto_hit;
  assign start_d = (state_q == IDLE) && (boot_q || go_d);

`ifdef IMAGE_SEQ_AUTO_EN
  logic [31:0] auto_q;

  assign auto_hit = (state_q == IDLE) &&
                    (auto_q == 32'(AUTO_PERIOD_CYCLES - 1));

  always_ff @(posedge i_clk or negedge i_resetL) begin
    if (!i_resetL) begin
      auto_q <= '0;
    end else if (state_q == IDLE && !start_d) begin
      auto_q <= auto_q + 1'b1;
    end else begin
      auto_q <= '0;
    end
  end
`else
  assign auto_hit = 1'b0;
`endif

  // boot_q forces the power-on load of image 0 without a press.
  always_ff @(posedge i_clk or negedge i_resetL) begin
    if (!i_resetL) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      rom_addr_q <= '0;
      fb_addr_q  <= '0;
      fb_we_q    <= 1'b0;
      flush_q    <= 1'b0;
      busy_q     <= 1'b0;
      pend_q     <= 1'b0;
      boot_q     <= 1'b1;
    end else begin
      fb_we_q <= (state_q == COPY);
      flush_q <= 1'b0;
      if (state_q == COPY) begin
        fb_addr_q <= rom_addr_q;
      end
      unique case (state_q)
        IDLE: begin
          if (start_d) begin
            state_q    <= COPY;
            busy_q     <= 1'b1;
            rom_addr_q <= '0;
            pend_q     <= 1'b0;
            boot_q     <= 1'b0;
            if (!boot_q) begin
              sel_q <= next_sel(sel_q, NUM_IMAGES);
            end
          end
        end
        COPY: begin
          if (press) pend_q <= 1'b1;
          if (rom_addr_q == LAST) begin
            state_q    <= DRAIN;
            rom_addr_q <= '0;
          end else begin
            rom_addr_q <= rom_addr_q + 1'b1;
          end
        end
        DRAIN: begin
          if (press) pend_q <= 1'b1;
          state_q <= DONE;
          flush_q <= 1'b1;
        end
        DONE: begin
          if (press) pend_q <= 1'b1;
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // ROM data lands one cycle after its address, so the pixel
  // passes straight through in the write cycle.
  assign o_fb_data  = fb_we_q ? i_rom_data : '0;
  assign o_rom_sel  = sel_q;
  assign o_rom_addr = rom_addr_q;
  assign o_fb_addr  = fb_addr_q;
  assign o_fb_we    = fb_we_q;
  assign o_flush    = flush_q;
  assign o_busy     = busy_q;

endmodule

// File: tb/tb_image_sequencer.sv
// Self-checking bench for image_sequencer with small image geometry.
// Define IMAGE_SEQ_AUTO_EN to exercise the idle auto-advance timer.
module tb_image_sequencer;
  import image_seq_pkg::*;

  localparam int NI = 3;
  localparam int PX = 16;
  localparam int DB = 4;

  logic i_clk = 1'b0;
  logic i_resetL = 1'b0;
  logic i_nextL = 1'b1;
  logic [1:0] o_rom_sel;
  logic [16:0] o_rom_addr;
  logic [2:0] i_rom_data = '0;
  logic [16:0] o_fb_addr;
  logic [2:0] o_fb_data;
  logic o_fb_we;
  logic o_flush;
  logic o_busy;

  always #5 i_clk = ~i_clk;

  image_sequencer #(
    .NUM_IMAGES(NI),
    .PIXELS(PX),
    .DEBOUNCE_CYCLES(DB)
`ifdef IMAGE_SEQ_AUTO_EN
    , .AUTO_PERIOD_CYCLES(20)
`endif
  ) dut (
    .i_clk(i_clk),
    .i_resetL(i_resetL),
    .i_nextL(i_nextL),
    .o_rom_sel(o_rom_sel),
    .o_rom_addr(o_rom_addr),
    .i_rom_data(i_rom_data),
    .o_fb_addr(o_fb_addr),
    .o_fb_data(o_fb_data),
    .o_fb_we(o_fb_we),
    .o_flush(o_flush),
    .o_busy(o_busy)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int model_sel = 0;
  int stray = 0;

  logic [2:0] rom_mem [NI][PX];

  always @(posedge i_clk) begin
    cyc <= cyc + 1;
    i_rom_data <= (o_rom_sel < 2'(NI)) ?
                  rom_mem[o_rom_sel][o_rom_addr[3:0]] : 3'd0;
  end

  typedef struct packed {
    logic [1:0]  sel;
    logic [7:0]  nwr;
    logic [7:0]  flen;
    logic        stable;
    logic [31:0] start_cyc;
    logic [31:0] flush_cyc;
  } copy_t;

  typedef struct packed {
    logic [7:0]  cidx;
    logic [16:0] addr;
    logic [2:0]  data;
  } wr_t;

  copy_t copies[$];
  wr_t   wrs[$];
  copy_t cur;
  bit    in_copy = 1'b0;

  // Observer: records each completed copy and its write stream.
  always @(negedge i_clk) begin
    if (!i_resetL) begin
      if (in_copy)
        while (wrs.size() > 0 && wrs[$].cidx == 8'(copies.size()))
          wrs.pop_back();
      in_copy = 1'b0;
    end else begin
      if (o_busy && !in_copy) begin
        in_copy = 1'b1;
        cur = '0;
        cur.sel = o_rom_sel;
        cur.stable = 1'b1;
        cur.start_cyc = cyc;
      end
      if (in_copy) begin
        cur.flen = cur.flen + 8'd1;
        if (o_rom_sel !== cur.sel) cur.stable = 1'b0;
        if (o_fb_we === 1'b1) begin
          wrs.push_back(wr_t'{cidx: 8'(copies.size()),
                              addr: o_fb_addr, data: o_fb_data});
          cur.nwr = cur.nwr + 8'd1;
        end
        if (o_flush === 1'b1) begin
          cur.flush_cyc = cyc;
          copies.push_back(cur);
          in_copy = 1'b0;
        end
      end else if (o_fb_we !== 1'b0) begin
        stray++;
      end
    end
  end

  // Number of writes of copy ci that differ from the ideal stream
  // addr 0..PX-1 carrying that image's ROM contents.
  function automatic int bad_writes(int ci);
    int k = 0;
    int bad = 0;
    int s = int'(copies[ci].sel);
    foreach (wrs[i]) begin
      if (wrs[i].cidx == 8'(ci)) begin
        if (k >= PX || s >= NI) bad++;
        else if (wrs[i].addr !== 17'(k) ||
                 wrs[i].data !== rom_mem[s][k]) bad++;
        k++;
      end
    end
    if (k != PX) bad++;
    return bad;
  endfunction

  task automatic wait_copies(int n, int budget);
    int t = 0;
    while (copies.size() < n && t < budget) begin
      @(negedge i_clk); #1;
      t++;
    end
    n_chk++;
    if (copies.size() < n) begin
      n_fail++;
      $display("FAIL wait_copies: got %0d copies, expected %0d",
               copies.size(), n);
    end
  endtask

  task automatic hold_low(int cycles);
    @(negedge i_clk);
    i_nextL = 1'b0;
    repeat (cycles) @(negedge i_clk);
    i_nextL = 1'b1;
  endtask

  task automatic test_reset();
    i_resetL = 1'b0;
    repeat (3) @(negedge i_clk);
    #1;
    n_chk++;
    if ({o_rom_sel, o_rom_addr, o_fb_addr, o_fb_data,
         o_fb_we, o_flush, o_busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got sel=%0d ra=%0d fa=%0d we=%b busy=%b expected all 0",
               o_rom_sel, o_rom_addr, o_fb_addr, o_fb_we, o_busy);
    end
    @(negedge i_clk);
    i_resetL = 1'b1;
    @(negedge i_clk); #1;
    n_chk++;
    if (o_busy !== 1'b1 || o_rom_addr !== 17'd0) begin
      n_fail++;
      $display("FAIL power_on_copy: got busy=%b addr=%0d expected busy=1 addr=0",
               o_busy, o_rom_addr);
    end
    wait_copies(1, 60);
    model_sel = 0;
    n_chk++;
    if (copies[0].sel !== 2'(model_sel) || copies[0].stable !== 1'b1) begin
      n_fail++;
      $display("FAIL power_on_sel: got %0d expected %0d", copies[0].sel, model_sel);
    end
    n_chk++;
    if (bad_writes(0) != 0 || copies[0].nwr !== 8'(PX)) begin
      n_fail++;
      $display("FAIL power_on_writes: got %0d writes %0d bad, expected %0d writes 0 bad",
               copies[0].nwr, bad_writes(0), PX);
    end
    n_chk++;
    if (copies[0].flen !== 8'(PX + 2)) begin
      n_fail++;
      $display("FAIL flush_latency: got busy cycle %0d expected %0d",
               copies[0].flen, PX + 2);
    end
    @(negedge i_clk); #1;
    n_chk++;
    if (o_busy !== 1'b0 || o_flush !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_done: got busy=%b flush=%b expected 0 0",
               o_busy, o_flush);
    end
  endtask

  task automatic test_debounce();
    int n0 = copies.size();
    hold_low(DB - 1);
    repeat (40) @(negedge i_clk);
    #1;
    n_chk++;
    if (copies.size() != n0 || o_rom_sel !== 2'(model_sel)) begin
      n_fail++;
      $display("FAIL short_press: got %0d copies sel %0d expected %0d sel %0d",
               copies.size(), o_rom_sel, n0, model_sel);
    end
    hold_low(10);
    wait_copies(n0 + 1, 80);
    model_sel = (model_sel + 1) % NI;
    repeat (30) @(negedge i_clk);
    #1;
    n_chk++;
    if (copies.size() != n0 + 1) begin
      n_fail++;
      $display("FAIL long_press_count: got %0d expected %0d",
               copies.size(), n0 + 1);
    end
    n_chk++;
    if (copies[n0].sel !== 2'(model_sel) || bad_writes(n0) != 0) begin
      n_fail++;
      $display("FAIL long_press_copy: got sel %0d bad %0d expected sel %0d bad 0",
               copies[n0].sel, bad_writes(n0), model_sel);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 5; i++) begin
      int n0 = copies.size();
      hold_low(6);
      wait_copies(n0 + 1, 80);
      model_sel = (model_sel + 1) % NI;
      n_chk++;
      if (copies[n0].sel !== 2'(model_sel) || bad_writes(n0) != 0 ||
          copies[n0].stable !== 1'b1) begin
        n_fail++;
        $display("FAIL wrap_%0d: got sel %0d bad %0d expected sel %0d bad 0",
                 i, copies[n0].sel, bad_writes(n0), model_sel);
      end
      repeat (4) @(negedge i_clk);
    end
  endtask

  task automatic test_pending();
    int n0 = copies.size();
    int t = 0;
    hold_low(DB);
    while (o_busy !== 1'b1 && t < 30) begin
      @(negedge i_clk);
      t++;
    end
    hold_low(DB);
    repeat (DB - 1) @(negedge i_clk);
    hold_low(DB);
    wait_copies(n0 + 2, 120);
    repeat (60) @(negedge i_clk);
    #1;
    n_chk++;
    if (copies.size() != n0 + 2) begin
      n_fail++;
      $display("FAIL pending_count: got %0d expected %0d",
               copies.size(), n0 + 2);
    end
    model_sel = (model_sel + 2) % NI;
    n_chk++;
    if (copies[n0 + 1].sel !== 2'(model_sel) || bad_writes(n0 + 1) != 0) begin
      n_fail++;
      $display("FAIL pending_copy: got sel %0d bad %0d expected sel %0d bad 0",
               copies[n0 + 1].sel, bad_writes(n0 + 1), model_sel);
    end
    n_chk++;
    if (copies[n0 + 1].start_cyc - copies[n0].flush_cyc != 32'd2) begin
      n_fail++;
      $display("FAIL pending_gap: got %0d expected 2",
               copies[n0 + 1].start_cyc - copies[n0].flush_cyc);
    end
  endtask

  task automatic test_reset_mid();
    int n0 = copies.size();
    int t = 0;
    @(negedge i_clk);
    i_nextL = 1'b0;
    while (!(o_busy === 1'b1 && o_rom_addr === 17'd7) && t < 80) begin
      @(negedge i_clk);
      t++;
      if (t == 8) i_nextL = 1'b1;
    end
    i_nextL = 1'b1;
    n_chk++;
    if (o_rom_addr !== 17'd7) begin
      n_fail++;
      $display("FAIL mid_reach: got addr %0d expected 7", o_rom_addr);
    end
    i_resetL = 1'b0;
    #1;
    n_chk++;
    if ({o_rom_sel, o_rom_addr, o_fb_addr, o_fb_data,
         o_fb_we, o_flush, o_busy} !== '0) begin
      n_fail++;
      $display("FAIL mid_async_reset: got sel=%0d ra=%0d fa=%0d we=%b busy=%b expected all 0",
               o_rom_sel, o_rom_addr, o_fb_addr, o_fb_we, o_busy);
    end
    repeat (3) @(negedge i_clk);
    i_resetL = 1'b1;
    model_sel = 0;
    wait_copies(n0 + 1, 60);
    n_chk++;
    if (copies[n0].sel !== 2'd0 || bad_writes(n0) != 0 ||
        copies[n0].flen !== 8'(PX + 2)) begin
      n_fail++;
      $display("FAIL mid_restart: got sel %0d bad %0d len %0d expected sel 0 bad 0 len %0d",
               copies[n0].sel, bad_writes(n0), copies[n0].flen, PX + 2);
    end
    repeat (4) @(negedge i_clk);
  endtask

  task automatic test_random();
    int exp_n = copies.size();
    for (int i = 0; i < 8; i++) begin
      int len = (i == 0) ? DB - 1 : (i == 1) ? DB : int'($urandom_range(1, 9));
      hold_low(len);
      repeat (45) @(negedge i_clk);
      #1;
      if (len >= DB) begin
        exp_n++;
        model_sel = (model_sel + 1) % NI;
      end
      n_chk++;
      if (copies.size() != exp_n || o_rom_sel !== 2'(model_sel)) begin
        n_fail++;
        $display("FAIL random_%0d_len%0d: got %0d copies sel %0d expected %0d sel %0d",
                 i, len, copies.size(), o_rom_sel, exp_n, model_sel);
      end
      if (len >= DB) begin
        n_chk++;
        if (bad_writes(exp_n - 1) != 0) begin
          n_fail++;
          $display("FAIL random_%0d_writes: got %0d bad expected 0",
                   i, bad_writes(exp_n - 1));
        end
      end
    end
  endtask

  task automatic test_auto();
    int n0 = copies.size();
    wait_copies(n0 + 2, 200);
    for (int j = 0; j < 2; j++) begin
      model_sel = (model_sel + 1) % NI;
      n_chk++;
      if (copies[n0 + j].sel !== 2'(model_sel) ||
          copies[n0 + j].start_cyc - copies[n0 + j - 1].flush_cyc != 32'd21) begin
        n_fail++;
        $display("FAIL auto_%0d: got sel %0d gap %0d expected sel %0d gap 21",
                 j, copies[n0 + j].sel,
                 copies[n0 + j].start_cyc - copies[n0 + j - 1].flush_cyc, model_sel);
      end
    end
  endtask

  initial begin
    for (int s = 0; s < NI; s++)
      for (int a = 0; a < PX; a++)
        rom_mem[s][a] = 3'($urandom);
    test_reset();
`ifdef IMAGE_SEQ_AUTO_EN
    test_auto();
`else
    test_debounce();
    test_wrap();
    test_pending();
    test_reset_mid();
    test_random();
`endif
    n_chk++;
    if (stray != 0) begin
      n_fail++;
      $display("FAIL stray_writes: got %0d expected 0", stray);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/image_sequencer.md
IMAGE_SEQUENCER -- requirements
Module: image_sequencer

Interface
REQ-001 SHALL have parameter NUM_IMAGES, default 3, number of selectable images (2..4).
REQ-002 SHALL have parameter PIXELS, default 76800, pixels per image (320x240).
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 500000, stable cycles required for a button edge.
REQ-004 SHALL have port i_clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port i_resetL  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port i_nextL  input  1  next-image button, active-low, asynchronous to i_clk.
REQ-007 SHALL have port o_rom_sel  output  2  image ROM select.
REQ-008 SHALL have port o_rom_addr  output  17  image ROM read address.
REQ-009 SHALL have port i_rom_data  input  3  ROM pixel, valid exactly 1 cycle after o_rom_addr.
REQ-010 SHALL have port o_fb_addr  output  17  frame buffer write address.
REQ-011 SHALL have port o_fb_data  output  3  frame buffer write pixel.
REQ-012 SHALL have port o_fb_we  output  1  frame buffer write enable.
REQ-013 SHALL have port o_flush  output  1  one-cycle pulse when an image copy completes.
REQ-014 SHALL have port o_busy  output  1  high while a copy is in progress.

Function
REQ-015 SHALL pass i_nextL through a 2-flop synchronizer before any use.
REQ-016 SHALL register a press only after the synchronized input is low for DEBOUNCE_CYCLES consecutive cycles, and re-arm only after it is high for DEBOUNCE_CYCLES consecutive cycles; holding the button yields exactly one press.
REQ-017 SHALL implement FSM states IDLE, COPY, DRAIN, DONE.
REQ-018 SHALL, in COPY, increment o_rom_addr by 1 each cycle from 0 to PIXELS-1, then go to DRAIN.
REQ-019 SHALL drive o_fb_we=1, o_fb_addr=previous-cycle o_rom_addr, o_fb_data=i_rom_data on every cycle after a COPY cycle (1-cycle latency compensation); DRAIN writes pixel PIXELS-1.
REQ-020 SHALL go DRAIN -> DONE, assert o_flush for exactly the DONE cycle, then go to IDLE.
REQ-021 SHALL assert o_busy in COPY, DRAIN and DONE; o_fb_we=0 in IDLE and DONE.
REQ-022 SHALL, on a press in IDLE, set o_rom_sel to o_rom_sel+1, wrapping NUM_IMAGES-1 -> 0, and enter COPY with o_rom_addr=0 on the next cycle.
REQ-023 SHALL latch a press during COPY/DRAIN/DONE in a one-deep pending flag; additional presses while pending are dropped; the pending press is serviced on the IDLE cycle following DONE.
REQ-024 SHALL never abort a copy in progress; o_rom_sel is stable from COPY entry through DONE.
REQ-025 SHALL write exactly PIXELS frame buffer locations per copy, no address beyond PIXELS-1.

Reset
REQ-026 SHALL, while i_resetL=0, force o_rom_sel=0, o_rom_addr=0, o_fb_addr=0, o_fb_data=0, o_fb_we=0, o_flush=0, o_busy=0, pending=0, debounce counters=0, state=IDLE.
REQ-027 SHALL, on the first cycle after reset release, enter COPY for image 0 (power-on load) without a press.
REQ-028 SHALL, on reset asserted mid-copy, drop the copy immediately and restart per REQ-027 after release.

Configuration
REQ-029 SHALL, with macro IMAGE_SEQ_AUTO_EN defined, add parameter AUTO_PERIOD_CYCLES (default 150000000) and a counter that runs only in IDLE, clears on leaving IDLE, and on reaching AUTO_PERIOD_CYCLES-1 acts as a press.
REQ-030 SHALL, without IMAGE_SEQ_AUTO_EN, contain no auto counter; images advance only by button.

Structure
REQ-031 SHALL place the FSM state enum, PIXEL_W=3 and ADDR_W=17 constants in shared package image_seq_pkg.
REQ-032 SHALL implement synchronizer plus debounce as sub-module button_debounce (outputs one-cycle press pulse).

Verification (PIXELS=16, DEBOUNCE_CYCLES=4, NUM_IMAGES=3)
REQ-033 SHALL verify: release reset -> o_busy=1, 16 writes addr 0..15 with data of ROM 0 at addr-1 latency, o_flush pulse 18 cycles after COPY entry.
REQ-034 SHALL verify: i_nextL low 3 cycles -> no advance; low 10 cycles -> exactly one copy with o_rom_sel=1.
REQ-035 SHALL verify: three presses from sel 2 sequence -> sel 0 wrap, then 1.
REQ-036 SHALL verify: two presses during a copy -> one further copy only, starting the cycle after IDLE entry.
REQ-037 SHALL verify: i_resetL low at addr 7 -> outputs zero asynchronously, copy of image 0 restarts at addr 0.
REQ-038 SHALL verify: with IMAGE_SEQ_AUTO_EN, AUTO_PERIOD_CYCLES=20 -> sel advances 20 cycles after each IDLE entry.
